operand_fetch_stage: RTL

// - Decode-side operand fetch and ID/EX pipeline register. Drives register file read selects from the

---
 rtl/operand_fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch and ID/EX pipeline register with EX/MEM bypass and a load-use interlock.
// Optional feature macro: FORWARD_EN (EX/MEM bypass). When it is undefined, any EX/MEM writer interlocks.
module operand_fetch_stage #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned WORD_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic [4:0]        rsel1,
    output logic [4:0]        rsel2,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic              em_wen,
    input  logic [4:0]        em_wsel,
    input  logic              em_load,
    input  logic [WORD_W-1:0] em_wdat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [WORD_W-1:0] out_opa,
    output logic [WORD_W-1:0] out_opb
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Bubbles still owed after the one inserted on the hazard cycle itself.
    localparam logic [2:0] STALL_INIT   = 3'(LOAD_LAT - 32'd1);
    localparam bit         MULTI_BUBBLE = (LOAD_LAT > 32'd1);

    // Register 0 is hardwired, so it never produces a match.
    function automatic logic reg_match(
        input logic       wen,
        input logic [4:0] wsel,
        input logic [4:0] rsel
    );
        return wen & (wsel != 5'd0) & (wsel == rsel);
    endfunction

    state_t            state_q,     state_d;
    logic [2:0]        stall_cnt_q, stall_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q,     instr_d;
    logic [31:0]       pc_q,        pc_d;
    logic [WORD_W-1:0] opa_q,       opa_d;
    logic [WORD_W-1:0] opb_q,       opb_d;

    logic              match1_s;
    logic              match2_s;
    logic              hazard_s;
    logic              adv_s;
    logic [WORD_W-1:0] opa_sel_s;
    logic [WORD_W-1:0] opb_sel_s;

    assign rsel1     = in_instr[25:21];
    assign rsel2     = in_instr[20:16];
    assign out_valid = out_valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_opa   = opa_q;
    assign out_opb   = opb_q;

`ifndef FORWARD_EN
    logic unused_s;
    assign unused_s = em_load ^ (^em_wdat);
`endif

    // Hazard detection, operand selection and input handshake.
    always_comb begin
        match1_s = reg_match(em_wen, em_wsel, rsel1);
        match2_s = reg_match(em_wen, em_wsel, rsel2);
        adv_s    = out_ready | ~out_valid_q;
`ifdef FORWARD_EN
        hazard_s  = in_valid & em_load & (match1_s | match2_s);
        opa_sel_s = (match1_s & ~em_load) ? em_wdat : rdat1;
        opb_sel_s = (match2_s & ~em_load) ? em_wdat : rdat2;
`else
        hazard_s  = in_valid & (match1_s | match2_s);
        opa_sel_s = rdat1;
        opb_sel_s = rdat2;
`endif
        in_ready = adv_s & ~hazard_s & (state_q == ST_RUN) & ~flush;
    end

    // Next-state for the interlock FSM and the ID/EX register.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        if (flush) begin
            out_valid_d = 1'b0;
            stall_cnt_d = 3'd0;
            state_d     = ST_RUN;
        end else if (adv_s) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard_s) begin
                        out_valid_d = 1'b0;
                        stall_cnt_d = STALL_INIT;
                        state_d     = MULTI_BUBBLE ? ST_STALL : ST_RUN;
                    end else if (in_valid) begin
                        out_valid_d = 1'b1;
                        instr_d     = in_instr;
                        pc_d        = in_pc;
                        opa_d       = opa_sel_s;
                        opb_d       = opb_sel_s;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_STALL: begin
                    out_valid_d = 1'b0;
                    // A zero count can only come from corruption; leave the stall rather than wrap.
                    if (stall_cnt_q <= 3'd1) begin
                        stall_cnt_d = 3'd0;
                        state_d     = ST_RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    stall_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and pipeline register update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 3'd0;
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            pc_q        <= 32'd0;
            opa_q       <= '0;
            opb_q       <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
        end
    end

endmodule
